// File: rtl/press_pkg.sv
// Shared definitions for the button gesture classifier: state encoding,
// default 100 MHz timing constants and a counter sizing helper.
package press_pkg;

   // FSM state encoding (3 bits)
   typedef logic [2:0] state_t;

   localparam state_t DISARM    = 3'd0;
   localparam state_t IDLE      = 3'd1;
   localparam state_t PRESS1    = 3'd2;
   localparam state_t WAIT2     = 3'd3;
   localparam state_t PRESS2    = 3'd4;
   localparam state_t LONG_HELD = 3'd5;

   // Default timing at 100 MHz: 0.5 s long, 0.25 s double window, 0.1 s repeat
   localparam int unsigned LONG_CYC_DEF   = 50_000_000;
   localparam int unsigned GAP_CYC_DEF    = 25_000_000;
   localparam int unsigned REPEAT_CYC_DEF = 10_000_000;

   // One-cycle gesture pulses, kept together so they share one register
   typedef struct packed {
      logic short_p;
      logic long_p;
      logic rep_p;
      logic dbl_p;
   } pulses_t;

   // Largest of three timing constants, used to size the shared counter
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button presses into short, long (with auto-repeat)
// and double gestures, emitting registered one-cycle pulses.
module press_classifier
   import press_pkg::*;
#(
   parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
   parameter int unsigned GAP_CYC    = GAP_CYC_DEF,
   parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF,
   parameter int unsigned CW         = $clog2(max3(LONG_CYC, GAP_CYC, REPEAT_CYC)) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_level,
   output logic short_press,
   output logic long_press,
   output logic repeat_press,
   output logic double_press,
   output logic busy
);

   // Terminal counts; every comparison is an equality against one of these
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

   // A value below 2 would make the terminal count zero and break the counting
   if (LONG_CYC < 2 || GAP_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_param
      $error("press_classifier: LONG_CYC, GAP_CYC and REPEAT_CYC must be >= 2");
   end

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   pulses_t       pulse_q, pulse_d;
   logic          busy_q;

   // State, counter and registered outputs; reset lands in DISARM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DISARM;
         cnt_q   <= '0;
         pulse_q <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   // Next state and counter update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         DISARM: begin
            // A button held through reset must be released before anything counts
            if (!pb_level) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            if (pb_level) begin
               state_d = PRESS1;
               cnt_d   = CW'(1);
            end
         end
         PRESS1: begin
            if (pb_level) begin
               if (cnt_q == LONG_LAST) begin
                  state_d = LONG_HELD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = WAIT2;
               cnt_d   = CW'(1);
            end
         end
         WAIT2: begin
            if (pb_level) begin
               state_d = PRESS2;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESS2: begin
            // Second press of a double is not timed
            if (!pb_level) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         LONG_HELD: begin
            if (pb_level) begin
               if (cnt_q == REP_LAST) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = DISARM;
            cnt_d   = '0;
         end
      endcase
   end

   // Pulse decode; each branch sets at most one pulse so they stay exclusive
   always_comb begin
      pulse_d = '0;
      case (state_q)
         PRESS1: begin
            pulse_d.long_p = pb_level && (cnt_q == LONG_LAST);
         end
         WAIT2: begin
            pulse_d.dbl_p   = pb_level;
            pulse_d.short_p = !pb_level && (cnt_q == GAP_LAST);
         end
         LONG_HELD: begin
            pulse_d.rep_p = pb_level && (cnt_q == REP_LAST);
         end
         default: begin
            pulse_d = '0;
         end
      endcase
   end

   assign short_press  = pulse_q.short_p;
   assign long_press   = pulse_q.long_p;
   assign repeat_press = pulse_q.rep_p;
   assign double_press = pulse_q.dbl_p;
   assign busy         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: directed gestures followed by
// randomized press/release runs, checked against a run-length model.
module tb_press_classifier;

   localparam int unsigned LONG = 20;
   localparam int unsigned GAP  = 10;
   localparam int unsigned REP  = 5;

   logic clk;
   logic rst;
   logic pb_level;
   logic short_press, long_press, repeat_press, double_press, busy;

   int total = 0;
   int bad   = 0;
   int edge_no = 0;

   press_classifier #(
      .LONG_CYC   (LONG),
      .GAP_CYC    (GAP),
      .REPEAT_CYC (REP)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .pb_level     (pb_level),
      .short_press  (short_press),
      .long_press   (long_press),
      .repeat_press (repeat_press),
      .double_press (double_press),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: describes gestures in terms of run lengths of the level
   bit armed;       // a low sample has been seen since reset
   bit run_val;     // level of the current run
   int run_len;     // samples in the current run
   int gap_len;     // length of the low run that preceded the current press
   bit cur_first;   // current press started from idle (not a double's second press)
   bit prev_ok;     // last press was a first press shorter than LONG, not yet resolved
   bit e_short, e_long, e_rep, e_dbl, e_busy;

   task automatic check(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %b expected %b", tag, edge_no, got, exp);
      end
   endtask

   task automatic model(input bit r, input bit p);
      e_short = 0; e_long = 0; e_rep = 0; e_dbl = 0;
      if (r) begin
         armed = 0; prev_ok = 0; cur_first = 0; run_len = 0;
         e_busy = 1;
      end else if (!armed) begin
         if (!p) begin
            armed = 1; run_val = 0; run_len = 1; prev_ok = 0; gap_len = 0;
         end
         e_busy = !armed;
      end else begin
         if (p != run_val) begin
            if (run_val) prev_ok = cur_first && (run_len < int'(LONG));
            else gap_len = run_len;
            if (p) begin
               cur_first = !(prev_ok && gap_len < int'(GAP));
               e_dbl = !cur_first;
               prev_ok = 0;
            end
            run_val = p;
            run_len = 1;
         end else begin
            run_len++;
         end
         if (p) begin
            if (cur_first) begin
               e_long = (run_len == int'(LONG));
               e_rep  = (run_len > int'(LONG)) && ((run_len - int'(LONG)) % int'(REP) == 0);
            end
            e_busy = 1;
         end else begin
            e_short = prev_ok && (run_len == int'(GAP));
            e_busy  = prev_ok && (run_len < int'(GAP));
         end
      end
   endtask

   // One clock: drive on the falling edge, model the rising edge, check just after
   task automatic step(input bit p, input bit r);
      @(negedge clk);
      pb_level = p;
      rst = r;
      @(posedge clk);
      edge_no++;
      model(r, p);
      #1;
      check("short_press",  short_press,  e_short);
      check("long_press",   long_press,   e_long);
      check("repeat_press", repeat_press, e_rep);
      check("double_press", double_press, e_dbl);
      check("busy",         busy,         e_busy);
   endtask

   task automatic hold(input bit p, input int n);
      for (int i = 0; i < n; i++) step(p, 1'b0);
   endtask

   int hi_len, lo_len;

   initial begin
      rst = 1'b1;
      pb_level = 1'b0;
      armed = 0; run_val = 0; run_len = 0; gap_len = 0;
      cur_first = 0; prev_ok = 0;

      // Reset state
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      hold(1'b0, 20);

      // Short press: 5 high, then the full gap
      hold(1'b1, 5);  hold(1'b0, 20);
      // Long press with repeats
      hold(1'b1, 40); hold(1'b0, 20);
      // Double press: 9 zeros between presses
      hold(1'b1, 5);  hold(1'b0, 9);  hold(1'b1, 5);  hold(1'b0, 20);
      // 10 zeros: short fires, next press is a fresh first press
      hold(1'b1, 5);  hold(1'b0, 10); hold(1'b1, 5);  hold(1'b0, 20);
      // Long boundary: LONG-1 is short, LONG is long
      hold(1'b1, LONG - 1); hold(1'b0, 20);
      hold(1'b1, LONG);     hold(1'b0, 20);
      // Reset mid long press with button held through and after reset
      hold(1'b1, 10);
      step(1'b1, 1'b1); step(1'b1, 1'b1);
      hold(1'b1, 38); hold(1'b0, 50);
      hold(1'b1, 5);  hold(1'b0, 20);

      // Randomized runs biased toward the timing boundaries
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 2))
            0:       hi_len = $urandom_range(1, 6);
            1:       hi_len = $urandom_range(LONG - 2, LONG + 1);
            default: hi_len = $urandom_range(LONG, LONG + 3 * REP + 2);
         endcase
         case ($urandom_range(0, 2))
            0:       lo_len = $urandom_range(1, 4);
            1:       lo_len = $urandom_range(GAP - 2, GAP + 1);
            default: lo_len = $urandom_range(GAP + 2, GAP + 8);
         endcase
         for (int i = 0; i < hi_len; i++) step(1'b1, ($urandom_range(0, 63) == 0));
         for (int i = 0; i < lo_len; i++) step(1'b0, ($urandom_range(0, 63) == 0));
      end
      hold(1'b0, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
